even_p_rx_3bit: RTL and testbench

EVEN_P_RX_3BIT -- requirements
Module: even_p_rx_3bit

---
 rtl/even_p_pkg.sv | 30 +++
 rtl/even_p_chk.sv | 26 ++
 rtl/even_p_rx_3bit.sv | 154 +++++++++++++++
 tb/tb_even_p_rx_3bit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/even_p_pkg.sv
// -----------------------------------------------------------------------------
// even_p_pkg
// Shared definitions for the even-parity serial receiver:
//   - DEFAULT_DATA_W / MAX_DATA_W : default and largest supported data width
//   - state_e                      : 2-bit receiver FSM state encoding
//   - ERR_CNT_MAX                  : saturation value of the optional error counter
//   - even_parity_err()            : XOR reduction over {data, parity}
// -----------------------------------------------------------------------------
package even_p_pkg;

  localparam int DEFAULT_DATA_W = 3;
  localparam int MAX_DATA_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_PAR  = 2'b10,
    ST_STOP = 2'b11
  } state_e;

  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  // Even parity holds when the total number of ones over data plus parity
  // bit is even, so the error flag is the XOR reduction of all of them.
  // Unused upper bits must be zero.
  function automatic logic even_parity_err(input logic [MAX_DATA_W:0] frame_bits);
    return ^frame_bits;
  endfunction

endpackage : even_p_pkg

// File: rtl/even_p_chk.sv
// -----------------------------------------------------------------------------
// even_p_chk
// Combinational even-parity checker for one received frame.
// Ports:
//   data_par [DATA_W:0] in  : {P, D(DATA_W-1)..D0}
//   err                 out : 1 when the XOR over data and P is 1
// -----------------------------------------------------------------------------
module even_p_chk
  import even_p_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic [DATA_W:0] data_par,
  output logic            err
);

  logic [MAX_DATA_W:0] padded_s;

  // Zero-extend to the helper's fixed width, then reduce.
  always_comb begin
    padded_s             = '0;
    padded_s[DATA_W:0]   = data_par;
    err                  = even_parity_err(padded_s);
  end

endmodule : even_p_chk

// File: rtl/even_p_rx_3bit.sv
// -----------------------------------------------------------------------------
// even_p_rx_3bit
// Serial receiver for frames: start(0), D0..D(DATA_W-1) LSB first, even
// parity bit P, stop(1). The line is sampled once per bit_en strobe.
// Optional feature macro: EVEN_P_ERR_CNT_EN adds a saturating 8-bit count of
// frames that had a parity or framing error.
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   bit_en    in   bit-rate strobe
//   sin       in   serial line, idle high
//   data_out  out  last received data word (DATA_W bits)
//   valid     out  one-cycle pulse when a frame completes
//   perr      out  parity error of last frame
//   ferr      out  framing error (stop sampled 0) of last frame
//   busy      out  receiver not idle
//   err_cnt   out  saturating error-frame count (EVEN_P_ERR_CNT_EN only)
// DATA_W must lie in 1..8.
// -----------------------------------------------------------------------------
module even_p_rx_3bit
  import even_p_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              sin,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              perr,
  output logic              ferr,
  output logic              busy
`ifdef EVEN_P_ERR_CNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam int              IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [DATA_W-1:0]  shift_q;
  logic               par_q;
  logic [DATA_W-1:0]  data_q;
  logic               valid_q;
  logic               perr_q;
  logic               ferr_q;
  logic               busy_q;
  logic               perr_s;

  // Parity of the frame held in the shift register plus captured P bit.
  even_p_chk #(
    .DATA_W (DATA_W)
  ) u_chk (
    .data_par ({par_q, shift_q}),
    .err      (perr_s)
  );

  // Receiver FSM with registered result outputs; everything holds when no strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (bit_en) begin
        case (state_q)
          ST_IDLE: begin
            if (!sin) begin
              state_q <= ST_DATA;
              idx_q   <= '0;
              busy_q  <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
          ST_DATA: begin
            shift_q[idx_q] <= sin;
            if (idx_q == IDX_LAST) begin
              state_q <= ST_PAR;
              idx_q   <= '0;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
            end
          end
          ST_PAR: begin
            par_q   <= sin;
            state_q <= ST_STOP;
          end
          ST_STOP: begin
            // Result is published on the edge that samples the stop bit,
            // so a start bit on the very next strobe is seen from IDLE.
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            data_q  <= shift_q;
            perr_q  <= perr_s;
            ferr_q  <= ~sin;
            valid_q <= 1'b1;
          end
          default: begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data_out = data_q;
  assign valid    = valid_q;
  assign perr     = perr_q;
  assign ferr     = ferr_q;
  assign busy     = busy_q;

`ifdef EVEN_P_ERR_CNT_EN
  logic [7:0] err_cnt_q;
  logic [7:0] err_cnt_d;
  logic       frame_done_s;

  // A frame completes on the stop-bit strobe; count it if either error flag will be set.
  always_comb begin
    frame_done_s = bit_en && (state_q == ST_STOP);
    if (frame_done_s && (perr_s || !sin) && (err_cnt_q != ERR_CNT_MAX)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Error counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule : even_p_rx_3bit

// File: tb/tb_even_p_rx_3bit.sv
// -----------------------------------------------------------------------------
// tb_even_p_rx_3bit
// Scoreboard bench: the stimulus pushes the expected frame result when it
// drives a frame; a monitor pops and compares on every valid pulse and also
// checks that outputs hold between pulses.
// -----------------------------------------------------------------------------
module tb_even_p_rx_3bit;

  localparam int DATA_W = 3;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              perr;
    logic              ferr;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              bit_en;
  logic              sin;
  logic [DATA_W-1:0] data_out;
  logic              valid;
  logic              perr;
  logic              ferr;
  logic              busy;
`ifdef EVEN_P_ERR_CNT_EN
  logic [7:0]        err_cnt;
`endif

  even_p_rx_3bit #(.DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bit_en   (bit_en),
    .sin      (sin),
    .data_out (data_out),
    .valid    (valid),
    .perr     (perr),
    .ferr     (ferr),
    .busy     (busy)
`ifdef EVEN_P_ERR_CNT_EN
    ,
    .err_cnt  (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  int   n_pushed = 0;
  int   n_valid  = 0;

  // Monitor-side model state
  logic [DATA_W-1:0] held_data;
  logic              held_perr;
  logic              held_ferr;
  int                model_cnt;
  logic              prev_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops on valid, tracks held outputs and error count.
  always @(negedge clk) begin
    if (rst) begin
      held_data  = '0;
      held_perr  = 1'b0;
      held_ferr  = 1'b0;
      model_cnt  = 0;
      prev_valid = 1'b0;
    end else begin
      if (valid) begin
        n_valid++;
        check("valid_pulse_width", {31'd0, prev_valid}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          held_data = e.data;
          held_perr = e.perr;
          held_ferr = e.ferr;
          if (e.perr || e.ferr) model_cnt = (model_cnt < 255) ? model_cnt + 1 : 255;
`ifdef EVEN_P_ERR_CNT_EN
          check("err_cnt", {24'd0, err_cnt}, model_cnt);
`endif
        end
      end
      check("data_out", {29'd0, data_out}, {29'd0, held_data});
      check("perr", {31'd0, perr}, {31'd0, held_perr});
      check("ferr", {31'd0, ferr}, {31'd0, held_ferr});
      prev_valid = valid;
    end
  end

  // One bit lasting `period` cycles, strobed on its last cycle.
  task automatic strobe_bit(input logic b, input int period);
    sin = b;
    for (int i = 1; i < period; i++) begin
      bit_en = 1'b0;
      @(posedge clk); #1;
    end
    bit_en = 1'b1;
    @(posedge clk); #1;
    bit_en = 1'b0;
  endtask

  // flip=1 sends the wrong parity bit; stop=0 produces a framing error.
  task automatic send_frame(input logic [DATA_W-1:0] d, input logic flip,
                            input logic stop, input int period);
    logic p;
    exp_t e;
    p = logic'($countones(d) % 2) ^ flip;
    strobe_bit(1'b0, period);
    check("busy_in_frame", {31'd0, busy}, 32'd1);
    for (int i = 0; i < DATA_W; i++) strobe_bit(d[i], period);
    strobe_bit(p, period);
    e.data = d;
    e.perr = logic'($countones({d, p}) % 2);
    e.ferr = ~stop;
    exp_q.push_back(e);
    n_pushed++;
    strobe_bit(stop, period);
  endtask

  initial begin
    rst = 1'b1; bit_en = 1'b0; sin = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle line: nothing happens
    for (int i = 0; i < 10; i++) begin
      bit_en = 1'b1; sin = 1'b1;
      @(posedge clk); #1;
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_valid", {31'd0, valid}, 32'd0);
    end
    bit_en = 1'b0;

    // Directed frames
    send_frame(3'b101, 1'b0, 1'b1, 1);
    send_frame(3'b111, 1'b1, 1'b1, 1);
    send_frame(3'b001, 1'b0, 1'b0, 1);

    // Reset after the second data bit, with bit_en high on the reset edge
    strobe_bit(1'b0, 1);
    strobe_bit(1'b0, 1);
    strobe_bit(1'b1, 1);
    rst = 1'b1; bit_en = 1'b1; sin = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bit_en = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_data", {29'd0, data_out}, 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("post_rst_no_valid", {31'd0, valid}, 32'd0);
    end
    send_frame(3'b110, 1'b0, 1'b1, 1);

    // Slow strobe, back-to-back
    send_frame(3'b011, 1'b0, 1'b1, 4);
    send_frame(3'b100, 1'b0, 1'b1, 4);

    // Random frames with optional idle gaps
    for (int n = 0; n < 40; n++) begin
      int per;
      per = int'($urandom_range(4, 1));
      for (int g = 0; g < int'($urandom_range(2, 0)); g++) strobe_bit(1'b1, per);
      send_frame(DATA_W'($urandom), ($urandom_range(3, 0) == 0),
                 ($urandom_range(4, 0) != 0), per);
    end

    // Saturation: 256 back-to-back parity-error frames
    for (int n = 0; n < 256; n++) send_frame(DATA_W'($urandom), 1'b1, 1'b1, 1);

    // Drain
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1;
    check("drain_queue", exp_q.size(), 32'd0);
    check("valid_count", n_valid, n_pushed);
`ifdef EVEN_P_ERR_CNT_EN
    check("err_cnt_saturated", {24'd0, err_cnt}, 32'd255);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_even_p_rx_3bit
